// File: rtl/pwm_serializer.sv
// Bit-serial waveform generator: accepts a DATA_W-bit word over valid/ready and
// shifts it out on pwm MSB- or LSB-first, each bit held for bit_div+1 clocks.
module pwm_serializer #(
    parameter int   DATA_W     = 8,
    parameter int   DIV_W      = 16,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  bit_div,
    input  logic              abort,
    output logic              pwm,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] sreg, sreg_n;
    logic              lsb_q, lsb_n;
    logic [DIV_W-1:0]  div_q, div_n;
    logic [DIV_W-1:0]  div_cnt, div_cnt_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic              pwm_n, busy_n, done_n;
    logic              accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && (state == IDLE) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            lsb_q   <= 1'b0;
            div_q   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            pwm     <= IDLE_LEVEL;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            sreg    <= sreg_n;
            lsb_q   <= lsb_n;
            div_q   <= div_n;
            div_cnt <= div_cnt_n;
            bit_cnt <= bit_cnt_n;
            pwm     <= pwm_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // The shift register always presents the current bit at one end, so the
    // next bit is simply the neighbour of that end in the shift direction.
    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        lsb_n     = lsb_q;
        div_n     = div_q;
        div_cnt_n = div_cnt;
        bit_cnt_n = bit_cnt;
        pwm_n     = pwm;
        busy_n    = busy;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                pwm_n  = IDLE_LEVEL;
                busy_n = 1'b0;
                if (accept) begin
                    sreg_n    = data_in;
                    lsb_n     = lsb_first;
                    div_n     = bit_div;
                    pwm_n     = lsb_first ? data_in[0] : data_in[DATA_W-1];
                    bit_cnt_n = CNT_W'(DATA_W - 1);
                    div_cnt_n = bit_div;
                    busy_n    = 1'b1;
                    state_n   = SHIFT;
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                    pwm_n   = IDLE_LEVEL;
                    busy_n  = 1'b0;
                end else if (div_cnt != '0) begin
                    div_cnt_n = div_cnt - DIV_W'(1);
                end else if (bit_cnt != '0) begin
                    if (lsb_q) begin
                        sreg_n = sreg >> 1;
                        pwm_n  = sreg[1];
                    end else begin
                        sreg_n = sreg << 1;
                        pwm_n  = sreg[DATA_W-2];
                    end
                    bit_cnt_n = bit_cnt - CNT_W'(1);
                    div_cnt_n = div_q;
                end else begin
                    state_n = IDLE;
                    pwm_n   = IDLE_LEVEL;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                pwm_n   = IDLE_LEVEL;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_serializer.sv
// Self-checking bench for pwm_serializer: a timeline model checked every cycle
// plus directed waveform captures against hand-computed literals.
module tb_pwm_serializer;

    localparam int DW = 8;
    localparam int VW = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          lsb_first = 1'b0;
    logic          abort     = 1'b0;
    logic [DW-1:0] data_in   = '0;
    logic [VW-1:0] bit_div   = '0;
    logic          in_ready, pwm, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    bit chk_en   = 1'b0;

    // Model: a word occupies edges 0..N-1 after acceptance, done follows at edge N.
    bit            m_active = 1'b0;
    bit            m_done   = 1'b0;
    logic [DW-1:0] m_word   = '0;
    bit            m_lsb    = 1'b0;
    int            m_div    = 0;
    int            m_t      = 0;

    pwm_serializer #(.DATA_W(DW), .DIV_W(VW), .IDLE_LEVEL(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .lsb_first (lsb_first),
        .bit_div   (bit_div),
        .abort     (abort),
        .pwm       (pwm),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (abort) begin
                    m_active <= 1'b0;
                end else if (m_t + 1 == DW * (m_div + 1)) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_t <= m_t + 1;
                end
            end else if (in_valid && !abort) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_word   <= data_in;
                m_lsb    <= lsb_first;
                m_div    <= int'(bit_div);
            end
        end
    end

    always @(negedge clk) begin
        int   idx;
        logic ep;
        if (done) n_done++;
        if (chk_en) begin
            idx = m_t / (m_div + 1);
            ep  = m_active ? (m_lsb ? m_word[idx] : m_word[DW-1-idx]) : 1'b0;
            chk("pwm", {31'd0, pwm}, {31'd0, ep});
            chk("busy", {31'd0, busy}, {31'd0, m_active});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("in_ready", {31'd0, in_ready}, {31'd0, !m_active});
        end
    end

    // Called at a negedge; seq holds the emitted bits in emission order (bit 7 first).
    task automatic send_capture(input logic [DW-1:0] d, input bit lsb, input int div,
                                input bit hold, input bit poke,
                                output logic [DW-1:0] seq, output int done_edge);
        data_in   = d;
        lsb_first = lsb;
        bit_div   = VW'(div);
        in_valid  = 1'b1;
        seq       = '0;
        done_edge = -1;
        @(posedge clk);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) in_valid = 1'b0;
            if (poke && k == 3) begin
                data_in   = ~d;
                bit_div   = 16'd5;
                lsb_first = ~lsb;
            end
            if (k % (div + 1) == 0 && k / (div + 1) < DW) seq[DW-1-k/(div+1)] = pwm;
            if (done) begin
                done_edge = k;
                break;
            end
        end
    endtask

    initial begin
        logic [DW-1:0] seq;
        int            de;
        int            d0;

        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_pwm", {31'd0, pwm}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // MSB first, no divider
        send_capture(8'hA5, 1'b0, 0, 1'b0, 1'b0, seq, de);
        chk("msb_seq", {24'd0, seq}, 32'h0000_00A5);
        chk("msb_done_edge", de, 32'd8);

        // LSB first, divider 2: 0xC1 emits 1,0,0,0,0,0,1,1
        @(negedge clk);
        send_capture(8'hC1, 1'b1, 2, 1'b0, 1'b0, seq, de);
        chk("lsb_seq", {24'd0, seq}, 32'h0000_0083);
        chk("lsb_done_edge", de, 32'd24);

        // Input isolation: inputs change mid-word and in_valid stays high
        @(negedge clk);
        send_capture(8'h3C, 1'b0, 1, 1'b1, 1'b1, seq, de);
        in_valid = 1'b0;
        chk("iso_seq", {24'd0, seq}, 32'h0000_003C);
        chk("iso_done_edge", de, 32'd16);

        // Back-to-back words with in_valid held
        repeat (2) @(negedge clk);
        d0 = n_done;
        send_capture(8'hFF, 1'b0, 0, 1'b1, 1'b0, seq, de);
        chk("b2b0_seq", {24'd0, seq}, 32'h0000_00FF);
        chk("b2b0_done_edge", de, 32'd8);
        send_capture(8'h00, 1'b0, 0, 1'b0, 1'b0, seq, de);
        chk("b2b1_seq", {24'd0, seq}, 32'h0000_0000);
        chk("b2b1_done_edge", de, 32'd8);
        @(negedge clk);
        chk("b2b_done_count", n_done - d0, 32'd2);

        // Abort during a word
        @(negedge clk);
        d0        = n_done;
        data_in   = 8'hA5;
        lsb_first = 1'b0;
        bit_div   = '0;
        in_valid  = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) in_valid = 1'b0;
            if (k == 3) abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        chk("abort_pwm", {31'd0, pwm}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", n_done - d0, 32'd0);

        // Abort in IDLE blocks acceptance
        data_in  = 8'hFF;
        in_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        chk("idle_abort_busy", {31'd0, busy}, 32'd0);
        chk("idle_abort_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        abort    = 1'b0;

        // Asynchronous reset mid-word
        @(negedge clk);
        d0       = n_done;
        data_in  = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) in_valid = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pwm", {31'd0, pwm}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_done", n_done - d0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
